mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Memory-stage load/store initiator that turns one pipeline request at a time into a transaction on the data RAM port (ram_size/ram_read/ram_write/ram_data/ram_word/ram_adr). It sits between the MIPS memory stage and the byte-organised data RAM. It supports LW/LH/LHU/LB/LBU/SW/SH/SB. It returns read data sign- or zero-extended to 32 bits, with a valid/ready handshake on both pipeline sides.

Parameters:
RAM_LATENCY, 1, cycles each ram_read/ram_write strobe is held before read data is sampled (legal range 1-15)
ADDR_LIMIT, 128, byte size of data RAM; any address >= ADDR_LIMIT faults

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = word, 1 = byte, 2 = halfword; 3 is treated as word
req_signed  in  1  sign-extend load result (LB/LH)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  32  load result, extended; 0 for stores
resp_fault  out  1  access rejected, no RAM strobe issued
ram_size  out  2  size code to RAM, same encoding as req_size
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_data  out  32  store data to RAM, right-aligned
ram_word  in  32  read data from RAM, right-aligned (byte in [7:0], half in [15:0])
ram_adr  out  32  byte address to RAM

Behaviour:
- Reset: synchronous, active-high. On a reset edge, every output goes to 0 except req_ready, which goes to 1. State goes to IDLE and the counter clears. Reset mid-transaction drops the strobes at that edge and discards the transaction; no response is produced.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch req_* into internal registers.
  - If the fault condition holds, go to RESP with resp_fault = 1.
  - Otherwise go to ACCESS: set ram_adr and ram_size, set ram_data = req_wdata, assert ram_write if req_we else ram_read, and load counter = RAM_LATENCY-1.
- ACCESS:
  - req_ready = 0.
  - ram_adr, ram_size, ram_data and the strobe are held stable for exactly RAM_LATENCY cycles.
  - On the last cycle (counter = 0), deassert the strobe at the edge, capture ram_word (loads only), and go to RESP.
- Load extension:
  - size 1: resp_rdata = {24{signed & ram_word[7]}, ram_word[7:0]}.
  - size 2: resp_rdata = {16{signed & ram_word[15]}, ram_word[15:0]}.
  - size 0/3: resp_rdata = ram_word; req_signed is ignored.
- RESP:
  - resp_valid = 1; resp_rdata and resp_fault are held stable until resp_ready.
  - On resp_valid & resp_ready, clear resp_valid, resp_rdata and resp_fault, and go to IDLE.
  - req_ready = 0 throughout; there is no same-cycle re-accept.
- Latency: request accepted at edge N; strobe high during cycles N+1..N+RAM_LATENCY; resp_valid first high at N+RAM_LATENCY+1. Throughput is at most one request per RAM_LATENCY+2 cycles.
- Fault condition: req_addr >= ADDR_LIMIT, or req_addr + bytes(size) > ADDR_LIMIT. A faulting request produces no RAM strobe and resp_valid at N+1 with resp_rdata = 0.
- Address wrap: 32-bit addresses are compared unsigned. 0xFFFF_FFFC faults; the size addition does not wrap.
- ram_read and ram_write are never high in the same cycle, and are never high outside ACCESS.
- Strobes and the address change only on clk edges, so a level-sensitive RAM sees a glitch-free transaction.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined: an access also faults when it is misaligned: halfword with addr[0] != 0, or word/size 3 with addr[1:0] != 0. The fault behaves exactly like an out-of-range fault (no strobe, resp_fault = 1, rdata = 0).
- Undefined: no alignment check. The address is forwarded unmodified and the RAM decides byte placement.

Test Plan:
- Reset with RAM_LATENCY=1: assert rst for 2 cycles during ACCESS of a store -> ram_write = 0 after the reset edge, req_ready = 1, resp_valid never asserted, RAM contents unchanged.
- Store/load word: SW addr 0x10 data 0x1234_5678, then LW 0x10 -> ram_write high exactly 1 cycle with ram_size = 0; load resp_rdata = 0x1234_5678, resp_valid at accept+2.
- Byte sign extension: RAM byte 0x80 at addr 0x13; LB -> 0xFFFF_FF80; LBU -> 0x0000_0080.
- Halfword: SH 0x8001 to 0x0A, then LH -> 0xFFFF_8001; LHU -> 0x0000_8001.
- Out of range: LW 0x80 and SB 0xFFFF_FFFF (ADDR_LIMIT=128) -> resp_fault = 1, rdata = 0, resp_valid at accept+1, no strobe.
- Back-pressure/latency: RAM_LATENCY=3, resp_ready held low 4 cycles -> strobe high 3 cycles, resp held stable, req_ready = 0 until the handshake. With MEM_ALIGN_CHECK_EN defined, LW 0x02 -> fault.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store initiator driving a byte-organised data RAM port.
// Optional misalignment faults are compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
   parameter int unsigned RAM_LATENCY = 1,
   parameter int unsigned ADDR_LIMIT  = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic [1:0]  ram_size,
   output logic        ram_read,
   output logic        ram_write,
   output logic [31:0] ram_data,
   input  logic [31:0] ram_word,
   output logic [31:0] ram_adr
);

   if (RAM_LATENCY == 0 || RAM_LATENCY > 15) begin : g_latency_range
      $error("RAM_LATENCY must be in the range 1..15");
   end

   localparam logic [32:0] LIMIT    = 33'(ADDR_LIMIT);
   localparam logic [3:0]  CNT_INIT = 4'(RAM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        lat_we;
   logic        lat_signed;

   logic [2:0]  nbytes;
   logic [32:0] end_addr;
   logic        misaligned;
   logic        fault;

   // Range check is done on 33 bits so addr + size can never wrap back in range.
   always_comb begin
      case (req_size)
         2'd1:    nbytes = 3'd1;
         2'd2:    nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      end_addr = {1'b0, req_addr} + {30'd0, nbytes};
`ifdef MEM_ALIGN_CHECK_EN
      case (req_size)
         2'd1:    misaligned = 1'b0;
         2'd2:    misaligned = req_addr[0];
         default: misaligned = |req_addr[1:0];
      endcase
`else
      misaligned = 1'b0;
`endif
      fault = ({1'b0, req_addr} >= LIMIT) || (end_addr > LIMIT) || misaligned;
   end

   function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic sgn);
      case (size)
         2'd1:    extend_load = {{24{sgn & w[7]}}, w[7:0]};
         2'd2:    extend_load = {{16{sgn & w[15]}}, w[15:0]};
         default: extend_load = w;
      endcase
   endfunction

   // ram_adr/ram_size/ram_data double as the latched request fields.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         lat_we     <= 1'b0;
         lat_signed <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_fault <= 1'b0;
         ram_size   <= '0;
         ram_read   <= 1'b0;
         ram_write  <= 1'b0;
         ram_data   <= '0;
         ram_adr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_we     <= req_we;
                  lat_signed <= req_signed;
                  req_ready  <= 1'b0;
                  if (fault) begin
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= '0;
                     state      <= RESP;
                  end else begin
                     ram_adr   <= req_addr;
                     ram_size  <= req_size;
                     ram_data  <= req_wdata;
                     ram_write <= req_we;
                     ram_read  <= ~req_we;
                     cnt       <= CNT_INIT;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  ram_read   <= 1'b0;
                  ram_write  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b0;
                  resp_rdata <= lat_we ? '0 : extend_load(ram_word, ram_size, lat_signed);
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_fault <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array RAM, reference memory model, random traffic.
module tb_mem_access_unit;

   localparam int unsigned LAT   = 3;
   localparam int unsigned LIMIT = 128;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [1:0]  ram_size;
   logic        ram_read;
   logic        ram_write;
   logic [31:0] ram_data;
   logic [31:0] ram_word;
   logic [31:0] ram_adr;

   mem_access_unit #(.RAM_LATENCY(LAT), .ADDR_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .ram_size(ram_size), .ram_read(ram_read), .ram_write(ram_write),
      .ram_data(ram_data), .ram_word(ram_word), .ram_adr(ram_adr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
   endfunction

   // RAM device: level-sensitive reads, write lands at an edge unless reset aborts it
   logic [7:0] ram [LIMIT];
   logic       mem_clear;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < int'(LIMIT); i++) ram[i] <= 8'h00;
      end else if (ram_write && !rst && ram_adr < LIMIT) begin
         for (int i = 0; i < nb(ram_size); i++)
            if (int'(ram_adr) + i < int'(LIMIT)) ram[int'(ram_adr) + i] <= ram_data[8*i +: 8];
      end
   end

   always_comb begin
      ram_word = 32'hA5C3_3C5A;
      if (ram_read && ram_adr < LIMIT) begin
         for (int i = 0; i < 4; i++)
            if (i < nb(ram_size) && int'(ram_adr) + i < int'(LIMIT))
               ram_word[8*i +: 8] = ram[int'(ram_adr) + i];
      end
   end

   // Reference model: flat byte memory plus the architectural load/store rules
   logic [7:0] ref_mem [LIMIT];

   function automatic bit model_fault(input logic [31:0] a, input logic [1:0] s);
      longint unsigned aa = longint'(a);
      bit f = (aa >= longint'(LIMIT)) || (aa + longint'(nb(s)) > longint'(LIMIT));
`ifdef MEM_ALIGN_CHECK_EN
      if (s == 2'd2 && a[0] != 1'b0) f = 1'b1;
      if ((s == 2'd0 || s == 2'd3) && a[1:0] != 2'b00) f = 1'b1;
`endif
      return f;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s,
                                              input logic sgn);
      logic [31:0] v = '0;
      for (int i = 0; i < nb(s); i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
      if (s == 2'd1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
      if (s == 2'd2 && sgn && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
      int          lat;
   } exp_t;

   exp_t expq[$];
   int   nonfault_count = 0;
   int   episodes = 0;

   logic        cur_we;
   logic [1:0]  cur_size;
   logic [31:0] cur_addr;
   logic [31:0] cur_wdata;

   // resp_ready driver: 0 = always ready, 1 = random, 2 = held low
   int rr_mode = 0;
   always @(posedge clk) begin
      #2;
      case (rr_mode)
         0:       resp_ready = 1'b1;
         1:       resp_ready = ($urandom_range(0, 9) < 7);
         default: resp_ready = 1'b0;
      endcase
   end

   // RAM-port monitor: transaction fields, strobe length, exclusivity
   int scnt = 0;
   always @(negedge clk) begin
      if (rst) begin
         scnt = 0;
      end else if (ram_read || ram_write) begin
         scnt++;
         chk("ram_adr", ram_adr, cur_addr);
         chk("ram_size", 32'(ram_size), 32'(cur_size));
         chk("ram_data", ram_data, cur_wdata);
         chk("strobes", {30'd0, ram_write, ram_read}, {30'd0, cur_we, ~cur_we});
         chk("req_ready_access", 32'(req_ready), 32'd0);
      end else if (scnt != 0) begin
         chk("strobe_len", 32'(scnt), 32'(LAT));
         episodes++;
         scnt = 0;
      end
   end

   // Response monitor: pops the scoreboard on each new response
   bit          in_resp = 0;
   bit          hs_prev = 0;
   logic [31:0] held_rdata;
   logic        held_fault;
   exp_t        cur;

   always @(negedge clk) begin
      if (rst) begin
         in_resp = 0;
         hs_prev = 0;
      end else begin
         if (hs_prev) chk("resp_valid_drop", 32'(resp_valid), 32'd0);
         hs_prev = 0;
         if (resp_valid) begin
            chk("req_ready_resp", 32'(req_ready), 32'd0);
            if (!in_resp) begin
               if (expq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got rdata %h fault %0b expected none (cycle %0d)",
                           resp_rdata, resp_fault, cyc);
               end else begin
                  cur = expq.pop_front();
                  chk("resp_latency", 32'(cyc), 32'(cur.acc + cur.lat));
                  chk("resp_rdata", resp_rdata, cur.rdata);
                  chk("resp_fault", 32'(resp_fault), 32'(cur.fault));
               end
               held_rdata = resp_rdata;
               held_fault = resp_fault;
               in_resp = 1;
            end else begin
               chk("rdata_stable", resp_rdata, held_rdata);
               chk("fault_stable", 32'(resp_fault), 32'(held_fault));
            end
            if (resp_ready) begin
               in_resp = 0;
               hs_prev = 1;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      bit   got = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles (cycle %0d)", cyc);
         return;
      end
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      cur_we = we; cur_size = size; cur_addr = addr; cur_wdata = wdata;
      e.acc = cyc + 1;
      if (model_fault(addr, size)) begin
         e.rdata = '0; e.fault = 1'b1; e.lat = 0;
      end else begin
         e.fault = 1'b0; e.lat = int'(LAT);
         nonfault_count++;
         if (we) begin
            e.rdata = '0;
            for (int i = 0; i < nb(size); i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
         end else begin
            e.rdata = model_load(addr, size, sgn);
         end
      end
      expq.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit done = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (expq.size() == 0 && !resp_valid && req_ready) begin
            done = 1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
      end
   endtask

   initial begin
      int bad;
      rst = 1'b1; mem_clear = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0;
      cur_we = 1'b0; cur_size = '0; cur_addr = '0; cur_wdata = '0;
      for (int i = 0; i < int'(LIMIT); i++) ref_mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_fault", 32'(resp_fault), 32'd0);
      chk("rst_strobes", {30'd0, ram_read, ram_write}, 32'd0);
      chk("rst_ram_adr", ram_adr, 32'd0);
      chk("rst_ram_data", ram_data, 32'd0);
      chk("rst_ram_size", 32'(ram_size), 32'd0);
      rst = 1'b0; mem_clear = 1'b0;

      // word, byte and halfword round trips
      do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'h1234_5678);
      do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
      do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_0080);
      do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0);
      do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
      do_req(1'b1, 2'd2, 1'b0, 32'h0A, 32'h0000_8001);
      do_req(1'b0, 2'd2, 1'b1, 32'h0A, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h0A, 32'h0);
      do_req(1'b0, 2'd3, 1'b1, 32'h10, 32'h0);

      // range boundaries
      do_req(1'b0, 2'd0, 1'b0, 32'h80, 32'h0);
      do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h55);
      do_req(1'b0, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'h0);
      do_req(1'b1, 2'd0, 1'b0, 32'h7C, 32'hDEAD_BEEF);
      do_req(1'b0, 2'd0, 1'b0, 32'h7C, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, 32'h7D, 32'h0);
      do_req(1'b0, 2'd1, 1'b1, 32'h7F, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h7F, 32'h0);
      do_req(1'b0, 2'd0, 1'b0, 32'h02, 32'h0);
      do_req(1'b0, 2'd2, 1'b0, 32'h0B, 32'h0);
      wait_idle();

      // reset while a store is on the RAM port: no write, no response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h20;
      req_wdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_strobes", {30'd0, ram_read, ram_write}, 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (LAT + 4) @(negedge clk);
      do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
      wait_idle();

      // back-pressure: response must hold while resp_ready stays low
      rr_mode = 2;
      do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
      repeat (LAT + 5) @(negedge clk);
      chk("bp_resp_held", 32'(resp_valid), 32'd1);
      rr_mode = 0;
      wait_idle();

      // random traffic with random back-pressure
      rr_mode = 1;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else a = 32'($urandom_range(0, LIMIT + 3));
         do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom);
      end
      rr_mode = 0;
      wait_idle();
      repeat (2) @(negedge clk);

      chk("strobe_episodes", 32'(episodes), 32'(nonfault_count));
      bad = 0;
      for (int i = 0; i < int'(LIMIT); i++) if (ram[i] !== ref_mem[i]) bad++;
      chk("ram_contents_bad_bytes", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
